// File: rtl/sum_accumulator.sv
// Accumulates a block of unsigned sum words into a saturating total and
// presents the total, sample count and overflow flag through a valid/ready hold.
module sum_accumulator #(
  parameter int IN_WIDTH  = 9,
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 in_ready,
  input  logic [CNT_WIDTH-1:0] len,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0] out_count_q, out_count_d;
  logic                 out_ovf_q, out_ovf_d;

  logic                 in_fire;
  logic [ACC_WIDTH-1:0] in_ext;
  logic [CNT_WIDTH-1:0] len_eff;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 sum_sat;
  logic [ACC_WIDTH-1:0] sum_val;

  // Returns {saturated, value}; the total clamps at all-ones instead of wrapping.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                 input logic [ACC_WIDTH-1:0] b);
    logic [ACC_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[ACC_WIDTH]) begin
      sat_add = {1'b1, {ACC_WIDTH{1'b1}}};
    end else begin
      sat_add = s;
    end
  endfunction

  assign in_fire  = in_valid && in_ready;
  assign in_ext   = ACC_WIDTH'(in_data);
  assign len_eff  = (len == '0) ? CNT_WIDTH'(1) : len;
  assign cnt_inc  = cnt_q + CNT_WIDTH'(1);
  assign {sum_sat, sum_val} = sat_add(acc_q, in_ext);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    ovf_d       = ovf_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          len_d = len_eff;
          acc_d = in_ext;
          cnt_d = CNT_WIDTH'(1);
          ovf_d = 1'b0;
          state_d = (len_eff == CNT_WIDTH'(1) || flush) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (in_fire) begin
          acc_d = sum_val;
          ovf_d = ovf_q | sum_sat;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q || flush) state_d = HOLD;
        end else if (flush) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Result registers capture the post-update totals so out_valid follows the last accept by one cycle.
    if (state_d == HOLD && state_q != HOLD) begin
      out_data_d  = acc_d;
      out_count_d = cnt_d;
      out_ovf_d   = ovf_d;
    end
  end

  // Handshake outputs
  always_comb begin
    in_ready  = rst && (state_q != HOLD);
    out_valid = (state_q == HOLD);
  end

  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: a default-width instance and an ACC_WIDTH=10
// instance share one stimulus stream; expected values are hand-computed.
module tb_sum_accumulator;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [8:0]  in_data;
  logic [3:0]  len;
  logic        flush;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_ovf;
  logic [15:0] a_out_data;
  logic [3:0]  a_out_count;
  logic        b_in_ready, b_out_valid, b_out_ovf;
  logic [9:0]  b_out_data;
  logic [3:0]  b_out_count;

  int checks;
  int errors;

  sum_accumulator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
    .len(len), .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_count(a_out_count), .out_ovf(a_out_ovf)
  );

  sum_accumulator #(.IN_WIDTH(9), .ACC_WIDTH(10), .CNT_WIDTH(4)) dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
    .len(len), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_count(b_out_count), .out_ovf(b_out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; len = '0; flush = 1'b0; out_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("reset in_ready", a_in_ready, 0);
    check("reset out_valid", a_out_valid, 0);
    check("reset out_data", a_out_data, 0);
    check("reset out_count", a_out_count, 0);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("in_ready after release", a_in_ready, 1);

    // len=3, 5+2+9
    len = 4'd3; in_valid = 1'b1; in_data = 9'd5; step();
    in_data = 9'd2; step();
    check("sum3 no early valid", a_out_valid, 0);
    in_data = 9'd9; step();
    check("sum3 out_valid", a_out_valid, 1);
    check("sum3 out_data", a_out_data, 16);
    check("sum3 out_count", a_out_count, 3);
    check("sum3 out_ovf", a_out_ovf, 0);
    check("sum3 in_ready in HOLD", a_in_ready, 0);
    in_valid = 1'b0; step();
    check("sum3 back to idle valid", a_out_valid, 0);
    check("sum3 back to idle ready", a_in_ready, 1);

    // eight samples of 510: saturates at 10 bits, fits in 16 bits
    len = 4'd8; in_valid = 1'b1; in_data = 9'd510;
    for (int i = 0; i < 8; i++) step();
    in_valid = 1'b0;
    check("sat10 out_valid", b_out_valid, 1);
    check("sat10 out_data", b_out_data, 1023);
    check("sat10 out_ovf", b_out_ovf, 1);
    check("sat10 out_count", b_out_count, 8);
    check("wide16 out_data", a_out_data, 4080);
    check("wide16 out_ovf", a_out_ovf, 0);
    step();

    // flush with simultaneous third sample
    len = 4'd5; in_valid = 1'b1; in_data = 9'd7; step();
    step();
    flush = 1'b1; step();
    check("flush out_valid", a_out_valid, 1);
    check("flush out_data", a_out_data, 21);
    check("flush out_count", a_out_count, 3);
    in_valid = 1'b0; flush = 1'b0; step();
    flush = 1'b1; step();
    check("idle flush no valid", a_out_valid, 0);
    flush = 1'b0; step();
    check("idle flush no valid later", a_out_valid, 0);
    check("idle flush ready", a_in_ready, 1);

    // HOLD stalled by out_ready=0 while in_valid and flush are active
    out_ready = 1'b0; len = 4'd1; in_valid = 1'b1; in_data = 9'd100; step();
    in_data = 9'd55; flush = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("stall in_ready", a_in_ready, 0);
      check("stall out_valid", a_out_valid, 1);
      check("stall out_data", a_out_data, 100);
      check("stall out_count", a_out_count, 1);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; step();
    check("stall release idle", a_out_valid, 0);
    in_valid = 1'b1; in_data = 9'd33; step();
    check("new block out_data", a_out_data, 33);
    check("new block out_count", a_out_count, 1);

    // back-to-back single-sample blocks with in_valid held high
    in_data = 9'd10; step();
    check("b2b stalled by HOLD", a_out_valid, 0);
    step();
    check("b2b first valid", a_out_valid, 1);
    check("b2b first data", a_out_data, 10);
    in_data = 9'd20; step();
    check("b2b gap ready", a_in_ready, 1);
    step();
    check("b2b second data", a_out_data, 20);
    in_valid = 1'b0; step();

    // reset mid-block
    len = 4'd4; in_valid = 1'b1; in_data = 9'd1; step();
    in_data = 9'd2; step();
    #2 rst = 1'b0;
    #1;
    check("midrst in_ready", a_in_ready, 0);
    check("midrst out_valid", a_out_valid, 0);
    check("midrst out_data", a_out_data, 0);
    check("midrst out_count", a_out_count, 0);
    check("midrst out_ovf", b_out_ovf, 0);
    in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    step();
    check("postrst no valid", a_out_valid, 0);
    len = 4'd1; in_valid = 1'b1; in_data = 9'd300; step();
    check("postrst out_data", a_out_data, 300);
    check("postrst out_count", a_out_count, 1);
    in_valid = 1'b0; step();

    // len=0 acts as 1
    len = 4'd0; in_valid = 1'b1; in_data = 9'd42; step();
    check("len0 out_valid", a_out_valid, 1);
    check("len0 out_data", a_out_data, 42);
    check("len0 out_count", a_out_count, 1);
    in_valid = 1'b0; step();

    // len=15 runs to cnt=15; len changes mid-block are ignored
    len = 4'd15; in_valid = 1'b1; in_data = 9'd1; step();
    len = 4'd2;
    for (int i = 0; i < 13; i++) step();
    check("len15 not yet done", a_out_valid, 0);
    step();
    check("len15 out_valid", a_out_valid, 1);
    check("len15 out_count", a_out_count, 15);
    check("len15 out_data", a_out_data, 15);
    in_valid = 1'b0; step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be named clk and rst.
REQ-002 Parameter IN_WIDTH, default 9: width of each incoming sum word from the upstream adder.
REQ-003 Parameter ACC_WIDTH, default 16: width of the accumulated total.
REQ-004 Parameter CNT_WIDTH, default 4: width of the block-length and sample-count fields.
REQ-005 Port clk, input, 1: rising-edge clock.
REQ-006 Port rst, input, 1: asynchronous active-low reset.
REQ-007 Port in_valid, input, 1: in_data holds a sum word.
REQ-008 Port in_data, input, IN_WIDTH: unsigned sum word from the adder.
REQ-009 Port in_ready, output, 1: block accepts in_data this cycle.
REQ-010 Port len, input, CNT_WIDTH: samples per block, sampled on the first accept of each block.
REQ-011 Port flush, input, 1: close the current block early.
REQ-012 Port out_valid, output, 1: the result fields are valid.
REQ-013 Port out_ready, input, 1: the downstream stage consumes the result.
REQ-014 Port out_data, output, ACC_WIDTH: the accumulated total.
REQ-015 Port out_count, output, CNT_WIDTH: the number of samples in the block.
REQ-016 Port out_ovf, output, 1: the total saturated.

Function
REQ-017 An input transfer SHALL occur when in_valid and in_ready are both 1 at a rising clk edge; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-018 The FSM SHALL have three states: IDLE, ACCUM and HOLD.
REQ-019 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in HOLD and while rst=0.
REQ-020 out_valid SHALL be 1 only in HOLD; out_data, out_count and out_ovf SHALL be registered and stable throughout HOLD.
REQ-021 IDLE, on an input transfer:
- len_q <= len, with len=0 treated as 1;
- acc <= zero-extended in_data, cnt <= 1, ovf <= 0;
- next state HOLD if len_q==1 or flush=1, else ACCUM.
REQ-022 IDLE, flush without a transfer: SHALL be ignored.
REQ-023 ACCUM, on an input transfer:
- acc <= acc + in_data, saturating at 2^ACC_WIDTH-1;
- ovf SHALL be set and remain sticky once saturation occurs;
- cnt <= cnt+1;
- next state HOLD when cnt+1 == len_q.
REQ-024 ACCUM, flush=1:
- with a simultaneous transfer, the sample SHALL be accumulated first, then the state SHALL go to HOLD;
- without a transfer, the state SHALL go to HOLD with the current acc and cnt.
REQ-025 On entry to HOLD: out_data <= acc, out_count <= cnt, out_ovf <= ovf.
REQ-026 HOLD, on an output transfer: next state IDLE, and in_ready=1 in the following cycle. The latency from the last accepted sample to out_valid SHALL be exactly 1 cycle.
REQ-027 HOLD, out_ready=0: all outputs SHALL hold indefinitely; flush and in_valid SHALL be ignored.
REQ-028 len changes after the first accept of a block SHALL NOT affect that block.
REQ-029 The count SHALL NOT wrap: with CNT_WIDTH=4, len=15 ends the block at cnt=15.
REQ-030 Back-to-back operation SHALL be supported: a new block MAY start the cycle after the HOLD->IDLE transfer, with no lost samples.

Reset
REQ-031 While rst=0, independent of clk:
- state = IDLE;
- acc, cnt, len_q, ovf = 0;
- out_data = 0, out_count = 0, out_ovf = 0;
- out_valid = 0, in_ready = 0.
REQ-032 Reset asserted mid-block or in HOLD SHALL discard the partial or pending result; no out_valid SHALL follow.
REQ-033 in_ready SHALL rise in the first cycle after rst deasserts.

Verification
REQ-034 len=3; inputs 5, 2, 9 back-to-back; out_ready=1 -> out_valid one cycle after the third accept, with out_data=16, out_count=3, out_ovf=0.
REQ-035 ACC_WIDTH=10, len=8; eight inputs of 510 -> out_data=1023, out_ovf=1, out_count=8.
REQ-036 len=5; inputs 7, 7, then flush with a third input 7 in the same cycle -> out_data=21, out_count=3; a flush pulse in IDLE produces no out_valid.
REQ-037 HOLD with out_ready held at 0 for 4 cycles while in_valid=1 -> in_ready=0 and outputs unchanged throughout; out_ready=1 -> IDLE, and the next sample starts a new block with acc equal to that sample.
REQ-038 rst pulled low during ACCUM after 2 of 4 samples -> all outputs 0 immediately; after release, len=1 with input 300 -> out_data=300, out_count=1.
REQ-039 len=0 with a single input 42 -> out_data=42, out_count=1.
